// File: rtl/sklansky_pipe_sub.sv
// Two-stage pipelined 16-bit subtractor (A - B - Bin) built on a Sklansky prefix carry tree.
// Optional Zero/Neg/Ovf flag outputs are enabled by defining SKLANSKY_SUB_FLAGS_EN.
module sklansky_pipe_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SKLANSKY_SUB_FLAGS_EN
  ,
  output logic             Zero,
  output logic             Neg,
  output logic             Ovf
`endif
);

  localparam int unsigned LEVELS = 4;

  generate
    if (WIDTH != 16 || (1 << LEVELS) != WIDTH) begin : g_width_check
      $error("sklansky_pipe_sub: WIDTH must be 16");
    end
  endgenerate

  // One Sklansky level: bits in the upper half of each 2^lvl block absorb the
  // group term of the top bit of the lower half.
  function automatic logic [2*WIDTH-1:0] prefix_level(input logic [WIDTH-1:0] g,
                                                      input logic [WIDTH-1:0] p,
                                                      input int unsigned lvl);
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    int unsigned      j;
    gn = g;
    pn = p;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (((i >> (lvl - 1)) & 32'd1) == 32'd1) begin
        j     = ((i >> lvl) << lvl) + (32'd1 << (lvl - 1)) - 32'd1;
        gn[i] = g[i] | (p[i] & g[j]);
        pn[i] = p[i] & p[j];
      end
    end
    return {gn, pn};
  endfunction

  logic             s1_valid;
  logic             s2_valid;
  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0] p0_c;
  logic [WIDTH-1:0] g0_c;
  logic [WIDTH-1:0] g1_c;
  logic [WIDTH-1:0] p1_c;
  logic [WIDTH-1:0] g2_c;
  logic [WIDTH-1:0] p2_c;
  logic             c0_c;

  logic [WIDTH-1:0] s1_p0;
  logic [WIDTH-1:0] s1_g2;
  logic [WIDTH-1:0] s1_p2;
  logic             s1_c0;
`ifdef SKLANSKY_SUB_FLAGS_EN
  logic             s1_a15;
  logic             s1_b15;
`endif

  logic [WIDTH-1:0] g3_c;
  logic [WIDTH-1:0] p3_c;
  logic [WIDTH-1:0] g4_c;
  logic [WIDTH-1:0] p4_c;
  logic [WIDTH:0]   carry_c;
  logic [WIDTH-1:0] diff_c;
  logic             bout_c;

  // Handshake: a stage moves when it is empty or the stage after it moves.
  assign s2_adv    = ~s2_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Stage 0: A + ~B + ~Bin, prefix levels 1 and 2.
  always_comb begin
    p0_c         = A ^ ~B;
    g0_c         = A & ~B;
    c0_c         = ~Bin;
    {g1_c, p1_c} = prefix_level(g0_c, p0_c, 32'd1);
    {g2_c, p2_c} = prefix_level(g1_c, p1_c, 32'd2);
  end

  // Stage 1 -> 2: prefix levels 3 and 4, then fold in the carry-in.
  always_comb begin
    {g3_c, p3_c}        = prefix_level(s1_g2, s1_p2, 32'd3);
    {g4_c, p4_c}        = prefix_level(g3_c, p3_c, 32'd4);
    carry_c[0]          = s1_c0;
    carry_c[WIDTH:1]    = g4_c | (p4_c & {WIDTH{s1_c0}});
    diff_c              = s1_p0 ^ carry_c[WIDTH-1:0];
    bout_c              = ~carry_c[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_p0    <= '0;
      s1_g2    <= '0;
      s1_p2    <= '0;
      s1_c0    <= 1'b0;
      Diff     <= '0;
      Bout     <= 1'b0;
`ifdef SKLANSKY_SUB_FLAGS_EN
      s1_a15   <= 1'b0;
      s1_b15   <= 1'b0;
      Zero     <= 1'b0;
      Neg      <= 1'b0;
      Ovf      <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s1_adv && in_valid) begin
        s1_p0  <= p0_c;
        s1_g2  <= g2_c;
        s1_p2  <= p2_c;
        s1_c0  <= c0_c;
`ifdef SKLANSKY_SUB_FLAGS_EN
        s1_a15 <= A[WIDTH-1];
        s1_b15 <= B[WIDTH-1];
`endif
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_adv && s1_valid) begin
        Diff <= diff_c;
        Bout <= bout_c;
`ifdef SKLANSKY_SUB_FLAGS_EN
        Zero <= (diff_c == '0);
        Neg  <= diff_c[WIDTH-1];
        Ovf  <= (s1_a15 ^ s1_b15) & (s1_a15 ^ diff_c[WIDTH-1]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_sklansky_pipe_sub.sv
// Scoreboard bench for sklansky_pipe_sub: expected results are queued on input
// transfer and checked on output transfer; flag checks follow SKLANSKY_SUB_FLAGS_EN.
module tb_sklansky_pipe_sub;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] Diff;
  logic        Bout;
`ifdef SKLANSKY_SUB_FLAGS_EN
  logic        Zero;
  logic        Neg;
  logic        Ovf;
`endif

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   pops = 0;
  logic last_accept = 1'b0;

  sklansky_pipe_sub dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff     (Diff),
    .Bout     (Bout)
`ifdef SKLANSKY_SUB_FLAGS_EN
    ,
    .Zero     (Zero),
    .Neg      (Neg),
    .Ovf      (Ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [16:0] t;
    int          r;
    exp_t        e;
    t      = {1'b0, a} - {1'b0, b} - 17'(bin);
    e.diff = t[15:0];
    e.bout = t[16];
    r      = int'($signed(a)) - int'($signed(b)) - int'(bin);
    e.zero = (e.diff == 16'h0000);
    e.neg  = e.diff[15];
    e.ovf  = (r < -32768) || (r > 32767);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: score transfers at the falling edge, then advance past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    last_accept = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("diff", 32'(Diff), 32'(e.diff));
        check("bout", 32'(Bout), 32'(e.bout));
`ifdef SKLANSKY_SUB_FLAGS_EN
        check("zero", 32'(Zero), 32'(e.zero));
        check("neg",  32'(Neg),  32'(e.neg));
        check("ovf",  32'(Ovf),  32'(e.ovf));
`endif
      end
      pops++;
    end
    if (last_accept) sb.push_back(model(A, B, Bin));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic bin);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    Bin      = bin;
  endtask

  task automatic drive_rand();
    drive(16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  int          accepts;
  int          pops_before;
  logic        have_held;
  logic [15:0] held;

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(Diff), 32'd0);
    check("rst_bout", 32'(Bout), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single op and latency
    drive(16'h0005, 16'h0003, 1'b0);
    tick();
    in_valid = 1'b0;
    check("lat_not_yet", 32'(out_valid), 32'd0);
    tick();
    check("lat_two", 32'(out_valid), 32'd1);
    check("single_diff", 32'(Diff), 32'h0002);
    tick();
    tick();

    // Borrow / wrap
    drive(16'h0000, 16'h0001, 1'b0);
    tick();
    drive(16'h1234, 16'h1234, 1'b1);
    tick();
    in_valid = 1'b0;
    check("wrap1_diff", 32'(Diff), 32'hFFFF);
    check("wrap1_bout", 32'(Bout), 32'd1);
    tick();
    check("wrap2_diff", 32'(Diff), 32'hFFFF);
    check("wrap2_bout", 32'(Bout), 32'd1);
    tick();
    tick();

    // Back-to-back random ops at full throughput
    pops_before = pops;
    for (int i = 0; i < 100; i++) begin
      drive_rand();
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) check("b2b_out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("b2b_count", 32'(pops - pops_before), 32'd100);
    check("b2b_drained", 32'(sb.size()), 32'd0);

    // Backpressure
    pops_before = pops;
    accepts     = 0;
    have_held   = 1'b0;
    held        = '0;
    out_ready   = 1'b0;
    drive_rand();
    for (int i = 0; i < 5; i++) begin
      tick();
      if (last_accept) begin
        accepts++;
        drive_rand();
      end
      if (out_valid) begin
        if (have_held) check("stall_diff", 32'(Diff), 32'(held));
        held      = Diff;
        have_held = 1'b1;
      end
    end
    check("bp_accepts", 32'(accepts), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("bp_count", 32'(pops - pops_before), 32'd2);
    check("bp_drained", 32'(sb.size()), 32'd0);

    // Reset with two ops in flight
    drive_rand();
    tick();
    drive_rand();
    tick();
    in_valid = 1'b0;
    check("mid_out_valid_pre", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_diff", 32'(Diff), 32'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_no_stale", 32'(out_valid), 32'd0);
    end

    // Flag corner values (diff/bout always checked; flags when enabled)
    drive(16'h8000, 16'h0001, 1'b0);
    tick();
    drive(16'h0007, 16'h0007, 1'b0);
    tick();
    in_valid = 1'b0;
    check("flag1_diff", 32'(Diff), 32'h7FFF);
`ifdef SKLANSKY_SUB_FLAGS_EN
    check("flag1_ovf", 32'(Ovf), 32'd1);
    check("flag1_neg", 32'(Neg), 32'd0);
    check("flag1_zero", 32'(Zero), 32'd0);
`endif
    tick();
    check("flag2_diff", 32'(Diff), 32'h0000);
`ifdef SKLANSKY_SUB_FLAGS_EN
    check("flag2_zero", 32'(Zero), 32'd1);
`endif
    for (int i = 0; i < 3; i++) tick();
    check("final_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
